dense_accum: RTL

Downstream accumulation stage for the dense (fully-connected) path. It consumes the per-chunk partial sums that `densing` produces on `out_dense_data`, one per 9-wide input chunk, and sums `num_chunks` of them plus a bias. It then applies an optional arithmetic shift and ReLU, saturates the result to `DATA_W`, and presents one neuron result per job on a valid/ready output to the writeback path.

---
 rtl/dense_accum_if.sv | 27 ++
 rtl/dense_accum.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dense_accum_if.sv
// Chunk-input and result-output streams of the dense accumulation stage.
// The slave side is the accumulator; the master side feeds chunks and drains results.
interface dense_accum_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/dense_accum.sv
// Sums num_chunks signed partial sums plus a bias, then applies shift, optional ReLU
// and saturation, and presents one result per job on a valid/ready output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no job; waiting for start
// S_ACCUM | adding chunk partial sums into acc until n_lat have arrived
// S_OUT   | result held on out_data/out_valid until the consumer takes it
module dense_accum #(
    parameter int DATA_W = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               num_chunks,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     relu_en,
    dense_accum_if.slave             bus,
    output logic                     busy,
    output logic                     sat,
    output logic                     overrun
);
    localparam int ACC_W = DATA_W + 8;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUT
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [7:0]               cnt;
    logic [7:0]               n_lat;
    logic                     relu_lat;

    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] res;
    logic                     clip;
    logic                     start_acc;

    // A start is only honoured when idle or when it coincides with the result handshake.
    assign start_acc = start && ((state == S_IDLE) || ((state == S_OUT) && bus.out_ready));

    always_comb begin
        sum     = acc + {{8{bus.in_data[DATA_W-1]}}, bus.in_data};
        shifted = sum >>> SHIFT;
        if (relu_lat && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        clip = 1'b0;
        res  = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            res  = SAT_MAX[DATA_W-1:0];
            clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res  = SAT_MIN[DATA_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            n_lat         <= '0;
            relu_lat      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            busy          <= 1'b0;
            sat           <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sat <= 1'b0;

            if (start_acc) begin
                acc      <= {{8{bias[DATA_W-1]}}, bias};
                cnt      <= '0;
                n_lat    <= (num_chunks == 8'd0) ? 8'd1 : num_chunks;
                relu_lat <= relu_en;
                busy     <= 1'b1;
                state    <= S_ACCUM;
            end

            case (state)
                S_IDLE: begin
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        if (cnt == n_lat - 8'd1) begin
                            bus.out_data  <= res;
                            bus.out_valid <= 1'b1;
                            sat           <= clip;
                            state         <= S_OUT;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (!start_acc) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Chunks seen outside ACCUM are lost; a same-cycle accepted start keeps the flag set.
            if (start_acc) begin
                overrun <= bus.in_valid;
            end else if (bus.in_valid && (state != S_ACCUM)) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule
